prn_reclaim_queue: RTL and testbench

In-order bookkeeping queue on the ROB side of the renamer. For every renamed instruction it records the destination mappings the instruction overwrote (old PRN) and installed (new PRN). On commit it returns the old PRNs to the renamer free list. On flush it unwinds the uncommitted entries youngest-first, returning new PRNs and emitting remap-restore beats.

---
 rtl/prn_reclaim_queue.sv | 133 +++++++++++++
 tb/tb_prn_reclaim_queue.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/prn_reclaim_queue.sv
// rtl/prn_reclaim_queue.sv - in-order old/new PRN bookkeeping queue with commit reclaim and youngest-first flush unwind
module prn_reclaim_queue #(
    parameter int ARN_BITS     = 6,
    parameter int PRN_BITS     = 6,
    parameter int MAX_OPERANDS = 3,
    parameter int DEPTH        = 16,
    localparam int TAG_BITS    = $clog2(DEPTH)
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic                                   alloc_valid,
    output logic                                   alloc_ready,
    output logic [TAG_BITS-1:0]                    alloc_tag,
    input  logic [MAX_OPERANDS-1:0]                alloc_dst_valid,
    input  logic [MAX_OPERANDS-1:0][ARN_BITS-1:0]  alloc_arn,
    input  logic [MAX_OPERANDS-1:0][PRN_BITS-1:0]  alloc_old_prn,
    input  logic [MAX_OPERANDS-1:0][PRN_BITS-1:0]  alloc_new_prn,
    input  logic                                   commit_valid,
    input  logic                                   flush,
    output logic [MAX_OPERANDS-1:0]                free_valid,
    output logic [MAX_OPERANDS-1:0][PRN_BITS-1:0]  free_prns,
    output logic [MAX_OPERANDS-1:0]                restore_valid,
    output logic [MAX_OPERANDS-1:0][ARN_BITS-1:0]  restore_arn,
    output logic [MAX_OPERANDS-1:0][PRN_BITS-1:0]  restore_prn,
    output logic                                   busy,
    output logic [TAG_BITS:0]                      count
);
    typedef enum logic {RUN, UNWIND} state_t;

    localparam logic [TAG_BITS:0]   CNT_ONE = 1;
    localparam logic [TAG_BITS-1:0] TAG_ONE = 1;

    state_t state, state_nxt;
    logic [TAG_BITS-1:0] head, tail, head_nxt, tail_nxt, tail_m1;
    logic [TAG_BITS:0]   cnt, cnt_nxt;
    logic                alloc_fire, commit_fire, unwind_pop;

    logic [MAX_OPERANDS-1:0]               mem_dv  [DEPTH];
    logic [MAX_OPERANDS-1:0][ARN_BITS-1:0] mem_arn [DEPTH];
    logic [MAX_OPERANDS-1:0][PRN_BITS-1:0] mem_old [DEPTH];
    logic [MAX_OPERANDS-1:0][PRN_BITS-1:0] mem_new [DEPTH];

    assign tail_m1     = tail - TAG_ONE;
    // count is a power of two at full, so its MSB alone marks "full"
    assign alloc_ready = (state == RUN) && !cnt[TAG_BITS];
    assign alloc_tag   = tail;
    assign count       = cnt;
    assign busy        = (state == UNWIND);

    always_comb begin
        state_nxt   = state;
        head_nxt    = head;
        tail_nxt    = tail;
        cnt_nxt     = cnt;
        alloc_fire  = 1'b0;
        commit_fire = 1'b0;
        unwind_pop  = 1'b0;
        case (state)
            RUN: begin
                if (flush) begin
                    if (cnt != '0) state_nxt = UNWIND;
                end else begin
                    alloc_fire  = alloc_valid && !cnt[TAG_BITS];
                    commit_fire = commit_valid && (cnt != '0);
                    if (alloc_fire)  tail_nxt = tail + TAG_ONE;
                    if (commit_fire) head_nxt = head + TAG_ONE;
                    case ({alloc_fire, commit_fire})
                        2'b10:   cnt_nxt = cnt + CNT_ONE;
                        2'b01:   cnt_nxt = cnt - CNT_ONE;
                        default: cnt_nxt = cnt;
                    endcase
                end
            end
            UNWIND: begin
                unwind_pop = 1'b1;
                tail_nxt   = tail_m1;
                cnt_nxt    = cnt - CNT_ONE;
                if (cnt == CNT_ONE) state_nxt = RUN;
            end
            default: state_nxt = RUN;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= RUN;
            head  <= '0;
            tail  <= '0;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            head  <= head_nxt;
            tail  <= tail_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (alloc_fire) begin
            mem_dv[tail]  <= alloc_dst_valid;
            mem_arn[tail] <= alloc_arn;
            mem_old[tail] <= alloc_old_prn;
            mem_new[tail] <= alloc_new_prn;
        end
    end

    // commit returns the overwritten mapping; unwind returns the new one and reinstalls the old
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            free_valid    <= '0;
            free_prns     <= '0;
            restore_valid <= '0;
            restore_arn   <= '0;
            restore_prn   <= '0;
        end else begin
            free_valid    <= '0;
            free_prns     <= '0;
            restore_valid <= '0;
            restore_arn   <= '0;
            restore_prn   <= '0;
            if (commit_fire) begin
                free_valid <= mem_dv[head];
                free_prns  <= mem_old[head];
            end else if (unwind_pop) begin
                free_valid    <= mem_dv[tail_m1];
                free_prns     <= mem_new[tail_m1];
                restore_valid <= mem_dv[tail_m1];
                restore_arn   <= mem_arn[tail_m1];
                restore_prn   <= mem_old[tail_m1];
            end
        end
    end
endmodule

// File: tb/tb_prn_reclaim_queue.sv
// tb/tb_prn_reclaim_queue.sv - table, directed and randomized model checks for prn_reclaim_queue
module tb_prn_reclaim_queue;
    typedef logic [2:0][5:0] six3_t;

    typedef struct {
        bit       rdy;
        int       tag;
        int       cnt;
        bit       busy;
        int       kind;     // 0 no beat, 1 commit beat, 2 unwind beat
        logic [2:0] fv;
        six3_t    fp;
        six3_t    ra;
        six3_t    rp;
    } exp_t;

    typedef struct {
        bit       av;
        logic [2:0] dv;
        six3_t    arn;
        six3_t    op;
        six3_t    np;
        bit       cv;
        bit       fl;
        exp_t     e;
    } vec_t;

    typedef struct {
        logic [2:0] dv;
        six3_t    arn;
        six3_t    op;
        six3_t    np;
    } ent_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        alloc_valid = 1'b0;
    logic        alloc_ready;
    logic [3:0]  alloc_tag;
    logic [2:0]  alloc_dst_valid = '0;
    six3_t       alloc_arn = '0;
    six3_t       alloc_old_prn = '0;
    six3_t       alloc_new_prn = '0;
    logic        commit_valid = 1'b0;
    logic        flush = 1'b0;
    logic [2:0]  free_valid;
    six3_t       free_prns;
    logic [2:0]  restore_valid;
    six3_t       restore_arn;
    six3_t       restore_prn;
    logic        busy;
    logic [4:0]  count;

    int total = 0;
    int bad = 0;

    ent_t mq[$];
    bit   m_unw;
    int   m_tail;

    prn_reclaim_queue dut (
        .clk(clk), .rst(rst),
        .alloc_valid(alloc_valid), .alloc_ready(alloc_ready), .alloc_tag(alloc_tag),
        .alloc_dst_valid(alloc_dst_valid), .alloc_arn(alloc_arn),
        .alloc_old_prn(alloc_old_prn), .alloc_new_prn(alloc_new_prn),
        .commit_valid(commit_valid), .flush(flush),
        .free_valid(free_valid), .free_prns(free_prns),
        .restore_valid(restore_valid), .restore_arn(restore_arn), .restore_prn(restore_prn),
        .busy(busy), .count(count)
    );

    always #5 clk = ~clk;

    function automatic six3_t mk(int a, int b, int c);
        six3_t r;
        r[0] = 6'(a);
        r[1] = 6'(b);
        r[2] = 6'(c);
        return r;
    endfunction

    function automatic exp_t mke(bit rdy, int tag, int cnt, bit bsy, int kind,
                                 logic [2:0] fv, six3_t fp, six3_t ra, six3_t rp);
        exp_t e;
        e.rdy = rdy; e.tag = tag; e.cnt = cnt; e.busy = bsy; e.kind = kind;
        e.fv = fv; e.fp = fp; e.ra = ra; e.rp = rp;
        return e;
    endfunction

    function automatic vec_t mkv(bit av, logic [2:0] dv, six3_t arn, six3_t op, six3_t np,
                                 bit cv, bit fl, exp_t e);
        vec_t v;
        v.av = av; v.dv = dv; v.arn = arn; v.op = op; v.np = np;
        v.cv = cv; v.fl = fl; v.e = e;
        return v;
    endfunction

    task automatic chk(string nm, int act, int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic check_outs(string nm, exp_t e);
        chk({nm, " alloc_ready"}, int'(alloc_ready), int'(e.rdy));
        chk({nm, " alloc_tag"}, int'(alloc_tag), e.tag);
        chk({nm, " count"}, int'(count), e.cnt);
        chk({nm, " busy"}, int'(busy), int'(e.busy));
        chk({nm, " free_valid"}, int'(free_valid), (e.kind != 0) ? int'(e.fv) : 0);
        chk({nm, " restore_valid"}, int'(restore_valid), (e.kind == 2) ? int'(e.fv) : 0);
        for (int i = 0; i < 3; i++) begin
            if (e.kind == 0) begin
                chk({nm, " idle free_prns"}, int'(free_prns[i]), 0);
            end else if (e.fv[i]) begin
                chk({nm, " free_prns"}, int'(free_prns[i]), int'(e.fp[i]));
            end
            if (e.kind != 2) begin
                chk({nm, " idle restore_arn"}, int'(restore_arn[i]), 0);
                chk({nm, " idle restore_prn"}, int'(restore_prn[i]), 0);
            end else if (e.fv[i]) begin
                chk({nm, " restore_arn"}, int'(restore_arn[i]), int'(e.ra[i]));
                chk({nm, " restore_prn"}, int'(restore_prn[i]), int'(e.rp[i]));
            end
        end
    endtask

    task automatic drive(bit av, logic [2:0] dv, six3_t arn, six3_t op, six3_t np, bit cv, bit fl);
        alloc_valid = av; alloc_dst_valid = dv; alloc_arn = arn;
        alloc_old_prn = op; alloc_new_prn = np; commit_valid = cv; flush = fl;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_reset();
        drive(0, 3'b000, '0, '0, '0, 0, 0);
        #2 rst = 1'b0;
        step();
        rst = 1'b1;
    endtask

    function automatic exp_t model_step(bit av, logic [2:0] dv, six3_t arn, six3_t op, six3_t np,
                                        bit cv, bit fl);
        exp_t e;
        ent_t x;
        bit   take_alloc, take_commit;
        e = mke(0, 0, 0, 0, 0, '0, '0, '0, '0);
        if (m_unw) begin
            x = mq.pop_back();
            m_tail = (m_tail + 15) % 16;
            e.kind = 2; e.fv = x.dv; e.fp = x.np; e.ra = x.arn; e.rp = x.op;
            if (mq.size() == 0) m_unw = 0;
        end else if (fl) begin
            if (mq.size() > 0) m_unw = 1;
        end else begin
            take_alloc  = av && (mq.size() < 16);
            take_commit = cv && (mq.size() > 0);
            if (take_commit) begin
                x = mq.pop_front();
                e.kind = 1; e.fv = x.dv; e.fp = x.op;
            end
            if (take_alloc) begin
                x.dv = dv; x.arn = arn; x.op = op; x.np = np;
                mq.push_back(x);
                m_tail = (m_tail + 1) % 16;
            end
        end
        e.cnt = mq.size();
        e.busy = m_unw;
        e.rdy = !m_unw && (mq.size() < 16);
        e.tag = m_tail;
        return e;
    endfunction

    initial begin
        vec_t  tbl[$];
        six3_t z;
        six3_t a;
        z = mk(0, 0, 0);
        a = mk(1, 2, 3);

        // in-order commit, then flush unwind with alloc held high
        tbl.push_back(mkv(1, 3'b011, a, mk(5, 6, 0), z, 0, 0, mke(1, 1, 1, 0, 0, '0, z, z, z)));
        tbl.push_back(mkv(1, 3'b001, a, mk(7, 0, 0), z, 0, 0, mke(1, 2, 2, 0, 0, '0, z, z, z)));
        tbl.push_back(mkv(1, 3'b111, a, mk(8, 9, 10), z, 0, 0, mke(1, 3, 3, 0, 0, '0, z, z, z)));
        tbl.push_back(mkv(0, 3'b000, z, z, z, 1, 0, mke(1, 3, 2, 0, 1, 3'b011, mk(5, 6, 0), z, z)));
        tbl.push_back(mkv(0, 3'b000, z, z, z, 1, 0, mke(1, 3, 1, 0, 1, 3'b001, mk(7, 0, 0), z, z)));
        tbl.push_back(mkv(0, 3'b000, z, z, z, 1, 0, mke(1, 3, 0, 0, 1, 3'b111, mk(8, 9, 10), z, z)));
        tbl.push_back(mkv(0, 3'b000, z, z, z, 1, 0, mke(1, 3, 0, 0, 0, '0, z, z, z)));
        tbl.push_back(mkv(1, 3'b001, mk(1, 0, 0), mk(20, 0, 0), mk(40, 0, 0), 0, 0, mke(1, 4, 1, 0, 0, '0, z, z, z)));
        tbl.push_back(mkv(1, 3'b001, mk(1, 0, 0), mk(40, 0, 0), mk(41, 0, 0), 0, 0, mke(1, 5, 2, 0, 0, '0, z, z, z)));
        tbl.push_back(mkv(1, 3'b001, mk(2, 0, 0), mk(22, 0, 0), mk(42, 0, 0), 0, 0, mke(1, 6, 3, 0, 0, '0, z, z, z)));
        tbl.push_back(mkv(1, 3'b001, mk(3, 0, 0), mk(11, 0, 0), mk(12, 0, 0), 0, 1, mke(0, 6, 3, 1, 0, '0, z, z, z)));
        tbl.push_back(mkv(1, 3'b001, mk(3, 0, 0), mk(11, 0, 0), mk(12, 0, 0), 0, 0,
                          mke(0, 5, 2, 1, 2, 3'b001, mk(42, 0, 0), mk(2, 0, 0), mk(22, 0, 0))));
        tbl.push_back(mkv(1, 3'b001, mk(3, 0, 0), mk(11, 0, 0), mk(12, 0, 0), 0, 0,
                          mke(0, 4, 1, 1, 2, 3'b001, mk(41, 0, 0), mk(1, 0, 0), mk(40, 0, 0))));
        tbl.push_back(mkv(1, 3'b001, mk(3, 0, 0), mk(11, 0, 0), mk(12, 0, 0), 0, 0,
                          mke(1, 3, 0, 0, 2, 3'b001, mk(40, 0, 0), mk(1, 0, 0), mk(20, 0, 0))));
        tbl.push_back(mkv(0, 3'b000, z, z, z, 0, 0, mke(1, 3, 0, 0, 0, '0, z, z, z)));

        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        repeat (3) step();
        check_outs("reset", mke(1, 0, 0, 0, 0, '0, z, z, z));

        for (int i = 0; i < tbl.size(); i++) begin
            drive(tbl[i].av, tbl[i].dv, tbl[i].arn, tbl[i].op, tbl[i].np, tbl[i].cv, tbl[i].fl);
            step();
            check_outs($sformatf("vec%0d", i), tbl[i].e);
        end

        // full: 16 allocs, then a dropped alloc alongside a commit
        for (int k = 0; k < 16; k++) begin
            drive(1, 3'b001, z, mk(k, 0, 0), z, 0, 0);
            step();
        end
        check_outs("full", mke(0, 3, 16, 0, 0, '0, z, z, z));
        drive(1, 3'b001, z, mk(60, 0, 0), z, 1, 0);
        step();
        check_outs("full alloc+commit", mke(1, 3, 15, 0, 1, 3'b001, mk(0, 0, 0), z, z));
        for (int k = 1; k < 16; k++) begin
            drive(0, 3'b000, z, z, z, 1, 0);
            step();
            check_outs($sformatf("drain%0d", k), mke(1, 3, 15 - k, 0, 1, 3'b001, mk(k, 0, 0), z, z));
        end

        // wrap-around with one resident entry
        pulse_reset();
        check_outs("reset2", mke(1, 0, 0, 0, 0, '0, z, z, z));
        drive(1, 3'b001, z, mk(50, 0, 0), z, 0, 0);
        step();
        check_outs("prefill", mke(1, 1, 1, 0, 0, '0, z, z, z));
        for (int k = 0; k < 40; k++) begin
            drive(1, 3'b001, z, mk(k + 1, 0, 0), z, 1, 0);
            step();
            check_outs($sformatf("wrap%0d", k),
                       mke(1, (2 + k) % 16, 1, 0, 1, 3'b001, mk((k == 0) ? 50 : k, 0, 0), z, z));
        end

        // reset in the second unwind cycle
        drive(1, 3'b001, z, z, z, 0, 0);
        step();
        step();
        drive(0, 3'b000, z, z, z, 0, 1);
        step();
        drive(0, 3'b000, z, z, z, 0, 0);
        step();
        chk("mid-unwind busy", int'(busy), 1);
        #2 rst = 1'b0;
        #1;
        check_outs("async reset", mke(1, 0, 0, 0, 0, '0, z, z, z));
        @(posedge clk);
        #1 rst = 1'b1;
        step();
        step();
        check_outs("after reset", mke(1, 0, 0, 0, 0, '0, z, z, z));

        // randomized against the queue model
        pulse_reset();
        mq.delete();
        m_unw = 0;
        m_tail = 0;
        for (int c = 0; c < 600; c++) begin
            bit av, cv, fl;
            logic [2:0] dv;
            six3_t arn, op, np;
            exp_t e;
            int pa;
            pa = (c < 300) ? 70 : 30;
            av = ($urandom_range(99) < pa);
            cv = ($urandom_range(99) < (100 - pa));
            fl = ($urandom_range(99) < 4);
            dv = 3'($urandom);
            arn = mk($urandom_range(61), $urandom_range(61), $urandom_range(61));
            op = mk($urandom_range(63), $urandom_range(63), $urandom_range(63));
            np = mk($urandom_range(63), $urandom_range(63), $urandom_range(63));
            drive(av, dv, arn, op, np, cv, fl);
            e = model_step(av, dv, arn, op, np, cv, fl);
            step();
            check_outs($sformatf("rand%0d", c), e);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
